// File: rtl/mod_loadwb.sv
// mod_loadwb: load/write-back formatting stage with a 2-entry skid buffer.
//   Selects the write-back source (load, auipc, lui, pass). It aligns and
//   extends load data and queues the result behind a valid/ready handshake.
//   Optional feature: define MISALIGN_TRAP_EN to flag misaligned loads through
//   out_err and zero their data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   sel, op             source select, load funct3
//   readdata, addr, tag raw memory word, address/PC, destination tag
//   out_valid/out_ready downstream handshake
//   out_data, out_tag   formatted write-back value and its tag
//   out_err             misaligned-load flag
module mod_loadwb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  readdata,
    input  logic [XLEN-1:0]  addr,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_val;
    entry_t           fmt;

`ifdef MISALIGN_TRAP_EN
    logic [2:0] off3;
    logic       misalign;
`endif

    // Load alignment and extension. Size casts of signed slices sign-extend;
    // at XLEN=32 the 32-bit and 64-bit cases collapse to the full word.
    always_comb begin
        off     = addr[OFF_W-1:0];
        shifted = readdata >> {off, 3'b000};
        case (op)
            3'b000:  load_val = XLEN'($signed(shifted[7:0]));
            3'b001:  load_val = XLEN'($signed(shifted[15:0]));
            3'b010:  load_val = XLEN'($signed(shifted[31:0]));
            3'b100:  load_val = XLEN'(shifted[7:0]);
            3'b101:  load_val = XLEN'(shifted[15:0]);
            3'b110:  load_val = XLEN'(shifted[31:0]);
            default: load_val = shifted;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // off3[2] is always 0 at XLEN=32, so LD degenerates to the LW check there.
    always_comb begin
        off3 = 3'(off);
        case (op)
            3'b001, 3'b101: misalign = off3[0];
            3'b010, 3'b110: misalign = (off3[1:0] != 2'b00);
            3'b011:         misalign = (off3 != 3'b000);
            default:        misalign = 1'b0;
        endcase
    end
`endif

    // Source select; only load entries can carry an error.
    always_comb begin
        fmt.tag  = tag;
        fmt.err  = 1'b0;
        fmt.data = readdata;
        case (sel)
            2'b00: begin
                fmt.data = load_val;
`ifdef MISALIGN_TRAP_EN
                if (misalign) begin
                    fmt.data = '0;
                    fmt.err  = 1'b1;
                end
`endif
            end
            2'b01:   fmt.data = addr;
            2'b10:   fmt.data = '0;
            default: fmt.data = readdata;
        endcase
    end

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    // Buffer control: the output register refills from skid first to keep order.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        accept       = in_valid && in_ready_q;
        drain        = out_valid_q && out_ready;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = fmt;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = fmt;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_tag   = out_q.tag;
    assign out_err   = out_q.err;

endmodule

// File: tb/tb_mod_loadwb.sv
// Scoreboard bench for mod_loadwb: one XLEN=32 and one XLEN=64 instance.
module tb_mod_loadwb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        iv32, ir32, ov32, or32, oe32;
    logic [1:0]  sel32;
    logic [2:0]  op32;
    logic [31:0] rd32, ad32, od32;
    logic [4:0]  tg32, ot32;

    logic        iv64, ir64, ov64, or64, oe64;
    logic [1:0]  sel64;
    logic [2:0]  op64;
    logic [63:0] rd64, ad64, od64;
    logic [4:0]  tg64, ot64;

    mod_loadwb #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .sel(sel32), .op(op32), .readdata(rd32), .addr(ad32), .tag(tg32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_tag(ot32),
        .out_err(oe32)
    );

    mod_loadwb #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .sel(sel64), .op(op64), .readdata(rd64), .addr(ad64), .tag(tg64),
        .out_valid(ov64), .out_ready(or64), .out_data(od64), .out_tag(ot64),
        .out_err(oe64)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push32(input logic [63:0] d, input logic [4:0] t, input logic e);
        exp_t x;
        x.data = d; x.tag = t; x.err = e;
        q32.push_back(x);
    endtask

    task automatic push64(input logic [63:0] d, input logic [4:0] t, input logic e);
        exp_t x;
        x.data = d; x.tag = t; x.err = e;
        q64.push_back(x);
    endtask

    // Offer one entry; the expectation is queued in the cycle it is accepted.
    task automatic send32(input logic [1:0] s, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] r, input logic [4:0] t,
                          input logic [63:0] ed, input logic ee);
        int n = 0;
        iv32 = 1'b1; sel32 = s; op32 = o; ad32 = a; rd32 = r; tg32 = t;
        @(negedge clk);
        while (!ir32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send32_in_ready", 64'(ir32), 64'd1);
        if (ir32) push32(ed, t, ee);
        @(posedge clk);
        #1 iv32 = 1'b0;
    endtask

    task automatic send64(input logic [1:0] s, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] r, input logic [4:0] t,
                          input logic [63:0] ed, input logic ee);
        int n = 0;
        iv64 = 1'b1; sel64 = s; op64 = o; ad64 = a; rd64 = r; tg64 = t;
        @(negedge clk);
        while (!ir64 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send64_in_ready", 64'(ir64), 64'd1);
        if (ir64) push64(ed, t, ee);
        @(posedge clk);
        #1 iv64 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    // Monitors: the head entry must be on the outputs whenever out_valid is
    // high (stalled or not); it retires on a transfer.
    always @(negedge clk) begin
        if (rst_n && ov32) begin
            if (q32.size() == 0) begin
                check("mon32_unexpected_tag", 64'(ot32), 64'h1f_dead);
            end else begin
                check("mon32_data", 64'(od32), q32[0].data);
                check("mon32_tag",  64'(ot32), 64'(q32[0].tag));
                check("mon32_err",  64'(oe32), 64'(q32[0].err));
                if (or32) void'(q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov64) begin
            if (q64.size() == 0) begin
                check("mon64_unexpected_tag", 64'(ot64), 64'h1f_dead);
            end else begin
                check("mon64_data", od64, q64[0].data);
                check("mon64_tag",  64'(ot64), 64'(q64[0].tag));
                check("mon64_err",  64'(oe64), 64'(q64[0].err));
                if (or64) void'(q64.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        iv32 = 0; sel32 = 0; op32 = 0; rd32 = 0; ad32 = 0; tg32 = 0; or32 = 1;
        iv64 = 0; sel64 = 0; op64 = 0; rd64 = 0; ad64 = 0; tg64 = 0; or64 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst32_out_valid", 64'(ov32), 64'd0);
        check("rst32_in_ready",  64'(ir32), 64'd1);
        check("rst32_out_data",  64'(od32), 64'd0);
        check("rst32_out_tag",   64'(ot32), 64'd0);
        check("rst32_out_err",   64'(oe32), 64'd0);
        check("rst64_out_valid", 64'(ov64), 64'd0);
        check("rst64_in_ready",  64'(ir64), 64'd1);
        check("rst64_out_data",  od64,      64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Accepted on the first edge after release, visible one cycle later.
        send32(2'b00, 3'b000, 32'h1003, 32'h80AABBCC, 5'd5, 64'hFFFFFF80, 1'b0);
        check("lat32_out_valid", 64'(ov32), 64'd1);
        send32(2'b00, 3'b101, 32'h2002, 32'h8001FFFF, 5'd6, 64'h00008001, 1'b0);
        send32(2'b01, 3'b000, 32'h0400, 32'h12345678, 5'd7, 64'h00000400, 1'b0);
        send32(2'b10, 3'b000, 32'h0400, 32'h12345678, 5'd8, 64'h00000000, 1'b0);
        send32(2'b11, 3'b001, 32'h0003, 32'hDEADBEEF, 5'd9, 64'hDEADBEEF, 1'b0);
        send32(2'b00, 3'b010, 32'h1002, 32'h12345678, 5'd10,
               TRAP ? 64'h0 : 64'h00001234, TRAP);
        send32(2'b00, 3'b001, 32'h1000, 32'h00008123, 5'd11, 64'hFFFF8123, 1'b0);
        send32(2'b00, 3'b100, 32'h1001, 32'h0000F000, 5'd12, 64'h000000F0, 1'b0);
        send32(2'b00, 3'b111, 32'h1001, 32'hAABBCCDD, 5'd13, 64'h00AABBCC, 1'b0);
        send32(2'b00, 3'b011, 32'h1000, 32'h80000000, 5'd14, 64'h80000000, 1'b0);
        send32(2'b01, 3'b001, 32'h1001, 32'h00ABCD00, 5'd15, 64'h00001001, 1'b0);
        send32(2'b00, 3'b001, 32'h1001, 32'h00ABCD00, 5'd16,
               TRAP ? 64'h0 : 64'hFFFFABCD, TRAP);

        send64(2'b00, 3'b011, 64'h8, 64'hF000_0000_0000_0001, 5'd1,
               64'hF000_0000_0000_0001, 1'b0);
        check("lat64_out_valid", 64'(ov64), 64'd1);
        send64(2'b00, 3'b110, 64'h4, 64'hF000_0000_0000_0001, 5'd2,
               64'h0000_0000_F000_0000, 1'b0);
        send64(2'b00, 3'b010, 64'h4, 64'h8000_0000_0000_0000, 5'd3,
               64'hFFFF_FFFF_8000_0000, 1'b0);
        send64(2'b00, 3'b011, 64'h4, 64'h1122_3344_5566_7788, 5'd4,
               TRAP ? 64'h0 : 64'h0000_0000_1122_3344, TRAP);
        send64(2'b00, 3'b000, 64'h7, 64'h8000_0000_0000_0000, 5'd5,
               64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        send64(2'b00, 3'b101, 64'h6, 64'h1234_0000_0000_0000, 5'd6,
               64'h0000_0000_0000_1234, 1'b0);
        wait_drain();

        // Stall with three back-to-back offers: two taken, third waits.
        @(posedge clk);
        #1 or32 = 1'b0;
        iv32 = 1'b1; sel32 = 2'b11; op32 = 3'b000; ad32 = 32'h0;
        rd32 = 32'hA1A1A1A1; tg32 = 5'd21;
        @(negedge clk);
        check("stall_in_ready_1", 64'(ir32), 64'd1);
        push32(64'hA1A1A1A1, 5'd21, 1'b0);
        @(posedge clk);
        #1 rd32 = 32'hA2A2A2A2; tg32 = 5'd22;
        @(negedge clk);
        check("stall_in_ready_2", 64'(ir32), 64'd1);
        push32(64'hA2A2A2A2, 5'd22, 1'b0);
        @(posedge clk);
        #1 rd32 = 32'hA3A3A3A3; tg32 = 5'd23;
        @(negedge clk);
        check("stall_in_ready_full", 64'(ir32), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_hold", 64'(ir32), 64'd0);
        check("stall_out_valid", 64'(ov32), 64'd1);
        @(posedge clk);
        #1 or32 = 1'b1;
        @(negedge clk);
        check("release_in_ready_pre", 64'(ir32), 64'd0);
        @(negedge clk);
        check("release_in_ready_post", 64'(ir32), 64'd1);
        push32(64'hA3A3A3A3, 5'd23, 1'b0);
        @(posedge clk);
        #1 iv32 = 1'b0;
        wait_drain();

        // Fill both entries under stall, then reset mid-operation.
        @(posedge clk);
        #1 or32 = 1'b0;
        iv32 = 1'b1; sel32 = 2'b10; tg32 = 5'd25;
        @(negedge clk);
        push32(64'h0, 5'd25, 1'b0);
        @(posedge clk);
        #1 tg32 = 5'd26;
        @(negedge clk);
        push32(64'h0, 5'd26, 1'b0);
        @(posedge clk);
        #1 iv32 = 1'b0;
        @(negedge clk);
        check("full_in_ready", 64'(ir32), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ov32), 64'd0);
        check("midrst_in_ready",  64'(ir32), 64'd1);
        check("midrst_out_data",  64'(od32), 64'd0);
        check("midrst_out_tag",   64'(ot32), 64'd0);
        check("midrst_out_err",   64'(oe32), 64'd0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        or32 = 1'b1;
        send32(2'b01, 3'b000, 32'h0000_0ABC, 32'h0, 5'd27, 64'h0000_0ABC, 1'b0);
        check("postrst_out_tag", 64'(ot32), 64'd27);
        repeat (3) @(posedge clk);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_loadwb.md
MOD_LOADWB -- requirements
Module: mod_loadwb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream entry present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the entry this cycle.
REQ-007 SHALL have port sel, input, 2, source select: 00 load, 01 auipc, 10 lui, 11 pass.
REQ-008 SHALL have port op, input, 3, load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU, 011 LD.
REQ-009 SHALL have port readdata, input, XLEN, raw memory word.
REQ-010 SHALL have port addr, input, XLEN, effective address (load) or PC (auipc).
REQ-011 SHALL have port tag, input, TAG_W, destination tag carried with the data.
REQ-012 SHALL have port out_valid, output, 1, formatted entry present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the entry.
REQ-014 SHALL have port out_data, output, XLEN, formatted write-back value.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the entry on out_data.
REQ-016 SHALL have port out_err, output, 1, misaligned-load flag for the entry on out_data.

Function
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL hold a 2-entry buffer (output register plus skid register); in_ready = skid register empty, driven from a flop.
REQ-019 SHALL present an accepted entry on out_data exactly 1 cycle after acceptance when the output register is empty or being drained that cycle.
REQ-020 SHALL, when the output is stalled (out_valid && !out_ready) and an entry is accepted, park it in the skid register and deassert in_ready the next cycle.
REQ-021 SHALL, on an output transfer with skid occupied, move skid to output and reassert in_ready the next cycle; entries leave strictly in acceptance order, none dropped or duplicated.
REQ-022 SHALL hold out_data, out_tag and out_err stable while out_valid && !out_ready.
REQ-023 SHALL, for sel=00, compute off = addr[log2(XLEN/8)-1:0], shift readdata right by 8*off, then take the low 8/16/32/64 bits per op, sign-extending for LB/LH/LW/LD and zero-extending for LBU/LHU/LWU.
REQ-024 SHALL treat LWU and LD as full-width LW when XLEN=32.
REQ-025 SHALL output addr for sel=01, zero for sel=10, readdata unmodified for sel=11.
REQ-026 SHALL treat op 111 as full-width load without extension.
REQ-027 SHALL zero-fill bytes shifted in beyond the top of readdata.
REQ-028 SHALL drive out_err only for sel=00 entries; out_err is 0 for every other sel.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, in_ready=1, out_data=0, out_tag=0, out_err=0, and both buffer entries empty.
REQ-030 SHALL discard any buffered entries when reset asserts mid-operation; none reappear after release.
REQ-031 SHALL accept a new entry on the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with MISALIGN_TRAP_EN defined, set out_err=1 and out_data=0 for sel=00 entries where LH/LHU has odd off, LW/LWU has off not a multiple of 4, or LD has off not a multiple of 8.
REQ-033 SHALL, without MISALIGN_TRAP_EN, tie out_err to 0 and format misaligned loads per REQ-023 and REQ-027.

Verification
REQ-034 SHALL check XLEN=32: sel=00, op=000, addr=0x1003, readdata=0x80AABBCC, out_ready=1 -> out_data=0xFFFFFF80 one cycle later, tag preserved.
REQ-035 SHALL check sel=00, op=101, addr=0x2002, readdata=0x8001FFFF -> out_data=0x00008001; sel=01, addr=0x400 -> out_data=0x400; sel=10 -> out_data=0.
REQ-036 SHALL check out_ready=0 for 3 cycles while 3 entries are offered back-to-back: 2 accepted, in_ready=0 from the cycle after the second; releasing out_ready drains tags in order.
REQ-037 SHALL check a stalled output with skid full, then rst_n pulsed low -> out_valid=0, in_ready=1 immediately; no old tag observed after release.
REQ-038 SHALL check MISALIGN_TRAP_EN defined: op=010, addr=0x1002 -> out_err=1, out_data=0; undefined -> out_err=0, out_data=readdata>>16 zero-filled in the upper half.
REQ-039 SHALL check XLEN=64: op=011, addr=0x8, readdata=0xF000_0000_0000_0001 -> out_data=0xF000_0000_0000_0001; op=110, addr=0x4 -> out_data=0x00000000F0000000.
